// File: rtl/keypad_scanner_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner and its
// downstream consumers (counter/BCD data-entry path).
package keypad_scanner_pkg;

    // Scanner FSM states: walking rows, confirming a press, key held,
    // confirming a release.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_e;

    // Column sense lines are pulled up; no key on the active row reads all ones.
    localparam logic [3:0] COLS_IDLE = 4'b1111;

    // True when exactly one column line is pulled low.
    function automatic logic col_is_single(input logic [3:0] col);
        return ($countones(~col) == 1);
    endfunction

    // Position of the low column line (lowest one wins if several are low).
    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Key code = row_index*4 + col_index.
    function automatic logic [3:0] make_key(input logic [1:0] row, input logic [3:0] col);
        return {row, col_index(col)};
    endfunction

    // Maps a key code to the legend printed on a standard 4x4 keypad:
    //   1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, with '*'->E and '#'->F.
    function automatic logic [3:0] key_to_hex(input logic [3:0] key);
        logic [3:0] hex;
        case (key)
            4'd0:    hex = 4'h1;
            4'd1:    hex = 4'h2;
            4'd2:    hex = 4'h3;
            4'd3:    hex = 4'hA;
            4'd4:    hex = 4'h4;
            4'd5:    hex = 4'h5;
            4'd6:    hex = 4'h6;
            4'd7:    hex = 4'hB;
            4'd8:    hex = 4'h7;
            4'd9:    hex = 4'h8;
            4'd10:   hex = 4'h9;
            4'd11:   hex = 4'hC;
            4'd12:   hex = 4'hE;
            4'd13:   hex = 4'h0;
            4'd14:   hex = 4'hF;
            default: hex = 4'hD;
        endcase
        return hex;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side signal bundle: row drive out, column sense in, and the
// decoded key report toward the consumer.
interface keypad_scanner_if;
    logic [3:0] o_row;      // row drive, active-low, one-hot-low
    logic [3:0] i_col;      // column sense, active-low, asynchronous
    logic [3:0] o_key;      // last accepted key code
    logic       o_valid;    // one-cycle pulse per accepted press
    logic       o_pressed;  // level while a key is accepted and not yet released

    // Scanner side.
    modport slave (
        output o_row,
        output o_key,
        output o_valid,
        output o_pressed,
        input  i_col
    );

    // Keypad/consumer side.
    modport master (
        input  o_row,
        input  o_key,
        input  o_valid,
        input  o_pressed,
        output i_col
    );
endinterface

// File: rtl/keypad_scanner_tick.sv
// Free-running divider: o_tick is high for one cycle every DIV cycles.
// Also usable as the digit-rate strobe of the multiplexed display.
module scan_tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap from DIV-1 back to zero; the tick marks the last count.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    assign o_tick = (cnt_q == LAST);

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: walks the rows one dwell at a time,
// samples the synchronised columns at the end of each dwell, debounces press
// and release over DEBOUNCE_SCANS ticks and reports one key code per press.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input logic             i_clk,
    input logic             i_rst,
    keypad_scanner_if.slave kp
);

    localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

    logic        scan_tick;

    logic [3:0]  col_meta_q;
    logic [3:0]  col_s_q;

    scan_state_e state_q,   state_d;
    logic [1:0]  row_q,     row_d;
    logic [3:0]  pat_q,     pat_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [3:0]  key_q,     key_d;
    logic        valid_q,   valid_d;
    logic        pressed_q, pressed_d;

    logic        col_idle;
    logic        col_single;
    logic        col_match;
    logic [3:0]  cnt_inc;
    logic [1:0]  row_next;

    scan_tick_gen #(
        .DIV    (SCAN_DIV)
    ) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (scan_tick)
    );

    // Two-flop synchroniser for the asynchronous column lines; idles high
    // like the pulled-up inputs so reset never looks like a key press.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            col_meta_q <= COLS_IDLE;
            col_s_q    <= COLS_IDLE;
        end else begin
            col_meta_q <= kp.i_col;
            col_s_q    <= col_meta_q;
        end
    end

    assign col_idle   = (col_s_q == COLS_IDLE);
    assign col_single = col_is_single(col_s_q);
    assign col_match  = (col_s_q == pat_q);
    assign cnt_inc    = cnt_q + 4'd1;
    assign row_next   = row_q + 2'd1;

    // Next-state and output decode; all decisions happen on scan_tick only,
    // at the end of a row dwell when the columns have settled.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        row_d     = row_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        valid_d   = 1'b0;
        pressed_d = pressed_q;

        if (scan_tick) begin
            case (state_q)
                SCAN: begin
                    if (col_idle) begin
                        row_d = row_next;
                    end else if (col_single) begin
                        // Freeze the row on the candidate key; the detection
                        // tick itself is the first matching scan.
                        pat_d = col_s_q;
                        cnt_d = 4'd1;
                        if (DB_TARGET <= 4'd1) begin
                            key_d     = make_key(row_q, col_s_q);
                            valid_d   = 1'b1;
                            pressed_d = 1'b1;
                            state_d   = HELD;
                        end else begin
                            state_d   = DEBOUNCE;
                        end
                    end else begin
                        // Several columns low: ghosting or multi-key, skip it.
                        row_d = row_next;
                    end
                end

                DEBOUNCE: begin
                    if (col_match) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB_TARGET) begin
                            key_d     = make_key(row_q, pat_q);
                            valid_d   = 1'b1;
                            pressed_d = 1'b1;
                            state_d   = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                        row_d   = row_next;
                    end
                end

                HELD: begin
                    // Rollover presses on the frozen row are ignored.
                    if (col_idle) begin
                        cnt_d = 4'd1;
                        if (DB_TARGET <= 4'd1) begin
                            pressed_d = 1'b0;
                            state_d   = SCAN;
                            row_d     = row_next;
                        end else begin
                            state_d   = RELEASE;
                        end
                    end
                end

                RELEASE: begin
                    if (col_idle) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB_TARGET) begin
                            pressed_d = 1'b0;
                            state_d   = SCAN;
                            row_d     = row_next;
                        end
                    end else begin
                        // Release bounce: still the same press, no new report.
                        state_d = HELD;
                    end
                end

                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    // FSM, row pointer, debounce counter and output registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= SCAN;
            row_q     <= 2'd0;
            pat_q     <= COLS_IDLE;
            cnt_q     <= 4'd0;
            key_q     <= 4'd0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
        end
    end

    assign kp.o_row     = ~(4'b0001 << row_q);
    assign kp.o_key     = key_q;
    assign kp.o_valid   = valid_q;
    assign kp.o_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A physical keypad model turns the set of pressed keys and the driven row
// into column levels; a tick-level reference model follows the scanning
// rules and is compared with the DUT every cycle, alongside a table of
// hand-derived scenario vectors and a few reset sequences.
module tb_keypad_scanner;

    localparam int DIV = 4;
    localparam int DS  = 3;

    localparam int M_SCAN = 0;
    localparam int M_DEB  = 1;
    localparam int M_HELD = 2;
    localparam int M_REL  = 3;

    logic        clk;
    logic        rst_n;
    logic [15:0] keys;        // bit r*4+c set = key at row r, column c pressed
    logic [3:0]  col_w;

    int checks;
    int failures;
    int edges;
    int valid_cnt;
    bit prev_valid;

    // Reference model state (tick level).
    int         m_mode;
    int         m_row;
    int         m_cnt;
    logic [3:0] m_pat;
    logic [3:0] m_key;
    bit         m_pressed;
    bit         m_valid;

    typedef struct {
        logic [15:0] keys;
        int          ticks;
        logic [3:0]  row;
        bit          pressed;
        int          valids;
        logic [3:0]  key;
    } vec_t;

    vec_t vecs[16];

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV       (DIV),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .kp    (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a column reads low when a pressed key sits on a driven row.
    always_comb begin
        col_w = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kif.o_row[r] && keys[r*4+c]) col_w[c] = 1'b0;
            end
        end
    end
    assign kif.i_col = col_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] seen_cols(input int row);
        logic [3:0] p;
        p = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (keys[row*4+c]) p[c] = 1'b0;
        end
        return p;
    endfunction

    function automatic logic [3:0] exp_row();
        logic [3:0] e;
        e = 4'b1111;
        e[m_row] = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        m_mode    = M_SCAN;
        m_row     = 0;
        m_cnt     = 0;
        m_pat     = 4'b1111;
        m_key     = 4'd0;
        m_pressed = 1'b0;
        m_valid   = 1'b0;
    endtask

    task automatic model_accept();
        int idx;
        idx = 0;
        for (int c = 3; c >= 0; c--) begin
            if (!m_pat[c]) idx = c;
        end
        m_key     = 4'(m_row * 4 + idx);
        m_valid   = 1'b1;
        m_pressed = 1'b1;
        m_mode    = M_HELD;
    endtask

    // One end-of-dwell decision, straight from the scanning rules.
    task automatic model_tick();
        logic [3:0] pat;
        int         zeros;
        pat     = seen_cols(m_row);
        zeros   = $countones(~pat);
        m_valid = 1'b0;
        case (m_mode)
            M_SCAN: begin
                if (zeros == 1) begin
                    m_pat  = pat;
                    m_cnt  = 1;
                    m_mode = M_DEB;
                    if (m_cnt >= DS) model_accept();
                end else begin
                    m_row = (m_row + 1) % 4;
                end
            end
            M_DEB: begin
                if (pat == m_pat) begin
                    m_cnt++;
                    if (m_cnt >= DS) model_accept();
                end else begin
                    m_mode = M_SCAN;
                    m_row  = (m_row + 1) % 4;
                end
            end
            M_HELD: begin
                if (zeros == 0) begin
                    m_cnt  = 1;
                    m_mode = M_REL;
                end
            end
            default: begin
                if (zeros == 0) begin
                    m_cnt++;
                    if (m_cnt >= DS) begin
                        m_pressed = 1'b0;
                        m_mode    = M_SCAN;
                        m_row     = (m_row + 1) % 4;
                    end
                end else begin
                    m_mode = M_HELD;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("row",     32'(kif.o_row),     32'(exp_row()));
        check("valid",   32'(kif.o_valid),   32'(m_valid));
        check("pressed", 32'(kif.o_pressed), 32'(m_pressed));
        check("key",     32'(kif.o_key),     32'(m_key));
        if (kif.o_valid) begin
            valid_cnt++;
            check("valid_back_to_back", 32'(prev_valid), 32'd0);
        end
        prev_valid = kif.o_valid;
    endtask

    // Runs n full row dwells starting just after a tick edge; the model is
    // advanced on tick edges and outputs are compared on every falling edge.
    task automatic run_ticks(input int n);
        repeat (n * DIV) begin
            @(posedge clk);
            edges++;
            if (edges % DIV == 0) model_tick();
            else m_valid = 1'b0;
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic release_reset(input logic [15:0] k);
        keys       = k;
        model_reset();
        edges      = 0;
        prev_valid = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_row"},     32'(kif.o_row),     32'(4'b1110));
        check({tag, "_valid"},   32'(kif.o_valid),   32'd0);
        check({tag, "_pressed"}, 32'(kif.o_pressed), 32'd0);
        check({tag, "_key"},     32'(kif.o_key),     32'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        edges      = 0;
        valid_cnt  = 0;
        prev_valid = 1'b0;
        keys       = 16'h0000;
        rst_n      = 1'b0;
        model_reset();

        // Hand-derived scenario table: {keys, ticks, row, pressed, valids, key}.
        vecs[0]  = '{16'h0000, 1, 4'b1101, 1'b0, 0, 4'd0};   // idle scan
        vecs[1]  = '{16'h0000, 3, 4'b1110, 1'b0, 0, 4'd0};   // wraps to row0
        vecs[2]  = '{16'h0200, 4, 4'b1011, 1'b0, 0, 4'd0};   // r2c1 found, 2 matches
        vecs[3]  = '{16'h0200, 1, 4'b1011, 1'b1, 1, 4'd9};   // 3rd match: accept
        vecs[4]  = '{16'h0200, 2, 4'b1011, 1'b1, 0, 4'd9};   // held, no repeat
        vecs[5]  = '{16'h0000, 2, 4'b1011, 1'b1, 0, 4'd9};   // release 2 ticks
        vecs[6]  = '{16'h0200, 1, 4'b1011, 1'b1, 0, 4'd9};   // glitch back to held
        vecs[7]  = '{16'h0000, 2, 4'b1011, 1'b1, 0, 4'd9};   // release restarts
        vecs[8]  = '{16'h0000, 1, 4'b0111, 1'b0, 0, 4'd9};   // 3rd idle tick: released
        vecs[9]  = '{16'h1000, 1, 4'b0111, 1'b0, 0, 4'd9};   // r3c0 found
        vecs[10] = '{16'h0000, 1, 4'b1110, 1'b0, 0, 4'd9};   // bounce: resume scan
        vecs[11] = '{16'h1000, 3, 4'b0111, 1'b0, 0, 4'd9};   // back round to row3
        vecs[12] = '{16'h1000, 3, 4'b0111, 1'b1, 1, 4'd12};  // stable press accepted
        vecs[13] = '{16'h0000, 3, 4'b1110, 1'b0, 0, 4'd12};  // clean release
        vecs[14] = '{16'h0005, 1, 4'b1101, 1'b0, 0, 4'd12};  // ghost 1010 skipped
        vecs[15] = '{16'h0005, 3, 4'b1110, 1'b0, 0, 4'd12};  // ghost row never taken

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        release_reset(16'h0000);

        for (int i = 0; i < 16; i++) begin
            keys      = vecs[i].keys;
            valid_cnt = 0;
            run_ticks(vecs[i].ticks);
            check($sformatf("vec%0d_row", i),     32'(kif.o_row),     32'(vecs[i].row));
            check($sformatf("vec%0d_pressed", i), 32'(kif.o_pressed), 32'(vecs[i].pressed));
            check($sformatf("vec%0d_valids", i),  valid_cnt,          vecs[i].valids);
            check($sformatf("vec%0d_key", i),     32'(kif.o_key),     32'(vecs[i].key));
        end

        // Reset during DEBOUNCE on row2: outputs return to reset values at once.
        keys = 16'h0200;
        run_ticks(3);
        check("deb_row_frozen", 32'(kif.o_row), 32'(4'b1011));
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_deb");
        repeat (2) @(negedge clk);

        // Key r0c3 held across reset release is detected afresh.
        release_reset(16'h0008);
        valid_cnt = 0;
        run_ticks(3);
        check("post_reset_valids",  valid_cnt,           1);
        check("post_reset_key",     32'(kif.o_key),      32'd3);
        check("post_reset_pressed", 32'(kif.o_pressed),  32'd1);
        run_ticks(2);

        // Reset while HELD drops o_pressed asynchronously.
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_held");
        repeat (2) @(negedge clk);
        release_reset(16'h0000);

        // Randomised presses, releases, bounces and multi-key patterns.
        for (int i = 0; i < 160; i++) begin
            int sel;
            int a;
            int b;
            sel = $urandom_range(0, 9);
            a   = $urandom_range(0, 15);
            b   = $urandom_range(0, 15);
            if (sel < 4)      keys = 16'h0000;
            else if (sel < 8) keys = 16'h0001 << a;
            else              keys = (16'h0001 << a) | (16'h0001 << b);
            run_ticks($urandom_range(1, 10));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
